// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter and access sequencer for the single-port
//               byte-addressed data memory. Master 0 (CPU load/store) has
//               fixed priority; master 1 wins after STARVE_MAX lost rounds.
//               Each access runs IDLE -> ACCESS -> RESP, one cycle each.
//               Optional macro DMEM_ARB_ALIGN_CHECK_EN adds a misaligned
//               word/half rejection at capture.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] ADDR_LIMIT = 'h0001FFFF,
  parameter int unsigned      STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [2:0]       m0_mode,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [2:0]       m1_mode,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_err,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  output logic [2:0]       mem_modeBU,
  output logic [1:0]       mem_ResultSrc,
  input  logic [WIDTH-1:0] mem_RD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  // Sequencer state and captured request attributes
  state_t           state_q, state_d;
  logic             win_q, win_d;        // 0 = master 0, 1 = master 1
  logic             we_q, we_d;
  logic             rej_q, rej_d;
  logic [3:0]       starve_q, starve_d;

  // Registered outputs; the memory-side registers double as the captured
  // address/data/mode of the access in flight
  logic [WIDTH-1:0] mem_a_q, mem_a_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic             mem_we_q, mem_we_d;
  logic [2:0]       mem_mode_q, mem_mode_d;
  logic [1:0]       mem_rsrc_q, mem_rsrc_d;
  logic             m0_gnt_q, m0_gnt_d;
  logic             m1_gnt_q, m1_gnt_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic             m0_err_q, m0_err_d;
  logic             m1_err_q, m1_err_d;

  // Arbitration and request validation (combinational)
  logic             w_any_req;
  logic             w_pick_m1;
  logic             w_sel_we;
  logic [2:0]       w_sel_mode;
  logic [WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_mode_ok;
  logic             w_range_ok;
  logic             w_align_ok;
  logic             w_reject;

  // Pick the winner and flag illegal requests before capture
  always_comb begin
    w_any_req   = m0_req | m1_req;
    w_pick_m1   = m1_req & (~m0_req | (starve_q == C_STARVE_MAX));
    w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
    w_sel_mode  = w_pick_m1 ? m1_mode  : m0_mode;
    w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
    w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
    w_mode_ok   = (w_sel_mode >= 3'b001) && (w_sel_mode <= 3'b101);
    w_range_ok  = (w_sel_addr < ADDR_LIMIT);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    w_align_ok  = !(((w_sel_mode == 3'b001) && (w_sel_addr[1:0] != 2'b00)) ||
                    (((w_sel_mode == 3'b010) || (w_sel_mode == 3'b100)) &&
                     w_sel_addr[0]));
`else
    w_align_ok  = 1'b1;
`endif
    w_reject    = !(w_mode_ok && w_range_ok && w_align_ok);
  end

  // Next-state and next-output computation; outputs default to 0 so every
  // strobe is a single-cycle pulse and the memory bus idles at 0
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    rej_d       = rej_q;
    starve_d    = starve_q;
    mem_a_d     = '0;
    mem_wd_d    = '0;
    mem_we_d    = 1'b0;
    mem_mode_d  = 3'b000;
    mem_rsrc_d  = 2'b00;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = '0;
    m1_rdata_d  = '0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!m1_req) begin
          starve_d = 4'd0;
        end
        if (w_any_req) begin
          state_d    = ST_ACCESS;
          win_d      = w_pick_m1;
          we_d       = w_sel_we;
          rej_d      = w_reject;
          mem_a_d    = w_sel_addr;
          mem_wd_d   = w_sel_wdata;
          mem_mode_d = w_sel_mode;
          mem_we_d   = w_sel_we & ~w_reject;
          mem_rsrc_d = (~w_sel_we & ~w_reject) ? 2'b01 : 2'b00;
          m0_gnt_d   = ~w_pick_m1;
          m1_gnt_d   = w_pick_m1;
          if (w_pick_m1) begin
            starve_d = 4'd0;
          end else if (m1_req && (starve_q != C_STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_ACCESS: begin
        // mem_RD is sampled here, on the edge that ends ACCESS
        state_d = ST_RESP;
        if (win_q) begin
          m1_rvalid_d = 1'b1;
          m1_err_d    = rej_q;
          m1_rdata_d  = (rej_q | we_q) ? '0 : mem_RD;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_err_d    = rej_q;
          m0_rdata_d  = (rej_q | we_q) ? '0 : mem_RD;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state register; asynchronous reset drops mem_WE at once so an
  // interrupted store never commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      rej_q       <= 1'b0;
      starve_q    <= 4'd0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= 3'b000;
      mem_rsrc_q  <= 2'b00;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      rej_q       <= rej_d;
      starve_q    <= starve_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      mem_we_q    <= mem_we_d;
      mem_mode_q  <= mem_mode_d;
      mem_rsrc_q  <= mem_rsrc_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign mem_A         = mem_a_q;
  assign mem_WD        = mem_wd_q;
  assign mem_WE        = mem_we_q;
  assign mem_modeBU    = mem_mode_q;
  assign mem_ResultSrc = mem_rsrc_q;
  assign m0_gnt        = m0_gnt_q;
  assign m1_gnt        = m1_gnt_q;
  assign m0_rvalid     = m0_rvalid_q;
  assign m1_rvalid     = m1_rvalid_q;
  assign m0_rdata      = m0_rdata_q;
  assign m1_rdata      = m1_rdata_q;
  assign m0_err        = m0_err_q;
  assign m1_err        = m1_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a byte-array memory
//               model behind the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [2:0]  m0_mode = 0, m1_mode = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic [2:0]  mem_modeBU;
  logic [1:0]  mem_ResultSrc;

  dmem_arbiter #(.WIDTH(32), .ADDR_LIMIT(32'h0001FFFF), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_modeBU(mem_modeBU),
    .mem_ResultSrc(mem_ResultSrc), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int rv_cnt = 0;

  typedef struct packed {
    logic        m;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model (little-endian, 1 KiB aliased) ------------
  logic [7:0] mem [0:1023];
  logic [9:0] ri;
  logic [7:0] b0, b1, b2, b3;
  assign ri = mem_A[9:0];
  assign b0 = mem[ri];
  assign b1 = mem[ri + 10'd1];
  assign b2 = mem[ri + 10'd2];
  assign b3 = mem[ri + 10'd3];

  always_comb begin
    mem_RD = 32'h0;
    case (mem_modeBU)
      3'b001: mem_RD = {b3, b2, b1, b0};
      3'b010: mem_RD = {{16{b1[7]}}, b1, b0};
      3'b100: mem_RD = {16'h0, b1, b0};
      3'b011: mem_RD = {{24{b0[7]}}, b0};
      3'b101: mem_RD = {24'h0, b0};
      default: mem_RD = 32'h0;
    endcase
  end

  // Preload, then commit stores seen during ACCESS at the closing edge
  // unless reset is active at that edge
  initial begin
    logic        pend;
    logic [9:0]  pa;
    logic [31:0] pd;
    logic [2:0]  pm;
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    mem[10'h000] = 8'h5A;
    mem[10'h200] = 8'h78; mem[10'h201] = 8'h56;
    mem[10'h202] = 8'h34; mem[10'h203] = 8'h12;
    mem[10'h300] = 8'h80;
    mem[10'h302] = 8'h01; mem[10'h303] = 8'h80;
    mem[10'h310] = 8'h55;
    mem[10'h3FE] = 8'h7F;
    pend = 1'b0; pa = '0; pd = '0; pm = '0;
    forever begin
      @(negedge clk);
      if (mem_WE) begin
        pend = 1'b1; pa = mem_A[9:0]; pd = mem_WD; pm = mem_modeBU;
      end
      @(posedge clk);
      if (pend && rst_n) begin
        mem[pa] = pd[7:0];
        if (pm == 3'b001 || pm == 3'b010 || pm == 3'b100) mem[pa + 10'd1] = pd[15:8];
        if (pm == 3'b001) begin
          mem[pa + 10'd2] = pd[23:16];
          mem[pa + 10'd3] = pd[31:24];
        end
      end
      pend = 1'b0;
    end
  end

  // ---------------- response monitor / scoreboard --------------------------
  always @(negedge clk) begin
    exp_t e;
    if (mem_WE) we_cnt++;
    if (m0_gnt & m1_gnt) chk("gnt_both", 1, 0);
    if (m0_rvalid | m1_rvalid) begin
      rv_cnt++;
      if (sb_q.size() == 0) begin
        chk("rv_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rv_master", {31'h0, m1_rvalid}, {31'h0, e.m});
        chk("rv_both", {31'h0, m0_rvalid & m1_rvalid}, 0);
        chk("rdata", e.m ? m1_rdata : m0_rdata, e.rd);
        chk("err", {31'h0, e.m ? m1_err : m0_err}, {31'h0, e.err});
        chk("loser_quiet", e.m ? (m0_rdata | {31'h0, m0_err}) : (m1_rdata | {31'h0, m1_err}), 0);
      end
    end
  end

  // ---------------- driver helpers ------------------------------------------
  task automatic drive(input logic m, input logic req, input logic we, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_mode = md; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_mode = md; m0_addr = a; m0_wdata = wd;
    end
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic access(input logic m, input logic we, input logic [2:0] md, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int   cnt;
    logic g;
    exp_t e;
    e.m = m; e.rd = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    drive(m, 1'b1, we, md, a, wd);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      g = m ? m1_gnt : m0_gnt;
    end while (!g && cnt < 20);
    if (!g) begin
      chk("gnt_timeout", 0, 1);
    end else begin
      chk("acc_mem_A", mem_A, a);
      chk("acc_mem_WE", {31'h0, mem_WE}, {31'h0, we & ~exp_err});
      chk("acc_rsrc", {30'h0, mem_ResultSrc}, (!we && !exp_err) ? 32'd1 : 32'd0);
    end
    drive(m, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    wait_drain();
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int   we0, rv0, n, cyc;
    exp_t e;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_WE,
                     mem_modeBU, mem_ResultSrc}, 0);
    chk("rst_data", m0_rdata | m1_rdata | mem_A | mem_WD, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store then load, with explicit cycle timing on the store
    e.m = 1'b0; e.rd = 32'h0; e.err = 1'b0;
    sb_q.push_back(e);
    we0 = we_cnt;
    drive(1'b0, 1'b1, 1'b1, 3'b001, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt", {31'h0, m0_gnt}, 1);
    chk("t1_we", {31'h0, mem_WE}, 1);
    chk("t1_addr", mem_A, 32'h100);
    chk("t1_wd", mem_WD, 32'hDEADBEEF);
    chk("t1_rsrc", {30'h0, mem_ResultSrc}, 0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_rvalid", {31'h0, m0_rvalid}, 1);
    chk("t1_we_off", {31'h0, mem_WE}, 0);
    chk("t1_we_cycles", we_cnt - we0, 1);
    chk("t1_memword", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'hDEADBEEF);
    wait_drain();
    access(1'b0, 1'b0, 3'b001, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // Both masters requesting continuously: m0 x4, m1, m0 x4, m1
    for (int k = 0; k < 10; k++) begin
      e.m = (k == 4 || k == 9);
      e.rd = e.m ? 32'h12345678 : 32'hDEADBEEF;
      e.err = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h200, 32'h0);
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m0_gnt | m1_gnt) n++;
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("starve_grants", n, 10);
    wait_drain();

    // Sign/zero extension through the memory path (master 1)
    access(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 32'hFFFFFF80, 1'b0);
    access(1'b1, 1'b0, 3'b101, 32'h300, 32'h0, 32'h00000080, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h302, 32'h0, 32'hFFFF8001, 1'b0);
    access(1'b1, 1'b0, 3'b100, 32'h302, 32'h0, 32'h00008001, 1'b0);

    // Rejections: out of range, limit boundary, illegal modes
    we0 = we_cnt;
    access(1'b0, 1'b1, 3'b001, 32'h00020000, 32'h11223344, 32'h0, 1'b1);
    chk("oor_no_we", we_cnt - we0, 0);
    chk("oor_mem", {24'h0, mem[10'h000]}, 32'h5A);
    access(1'b0, 1'b0, 3'b101, 32'h0001FFFF, 32'h0, 32'h0, 1'b1);
    access(1'b0, 1'b0, 3'b101, 32'h0001FFFE, 32'h0, 32'h7F, 1'b0);
    access(1'b1, 1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'b000, 32'h100, 32'h0, 32'h0, 1'b1);

    // Reset in the middle of an ACCESS carrying a store
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'b011, 32'h310, 32'h000000AA);
    @(negedge clk);
    chk("rst_pre_we", {31'h0, mem_WE}, 1);
    chk("rst_pre_gnt", {31'h0, m0_gnt}, 1);
    rv0 = rv_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", {31'h0, mem_WE}, 0);
    chk("rst_gnt_drop", {31'h0, m0_gnt}, 0);
    chk("rst_A_drop", mem_A, 0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_rvalid", rv_cnt - rv0, 0);
    chk("rst_mem_kept", {24'h0, mem[10'h310]}, 32'h55);
    access(1'b0, 1'b0, 3'b101, 32'h310, 32'h0, 32'h55, 1'b0);

    // Misaligned word load
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0, 1'b1);
`else
    access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0000DEAD, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter and access sequencer for the single-port byte-addressed data memory. Master 0 is the CPU load/store path; master 1 is a secondary requester such as a program/data loader or debug port. Each access is captured into registers, issued to the memory port for exactly one cycle, and answered with a registered response. Sits between the execute-stage load/store logic and the data memory.

Parameters:
WIDTH, 32, data and address width
ADDR_LIMIT, 32'h0001FFFF, first out-of-range byte address; accesses at or above it are rejected
STARVE_MAX, 4, consecutive lost arbitrations after which master 1 wins over master 0 (range 1-15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req / m1_req  in  1  access request; held stable until the matching gnt
m0_we / m1_we  in  1  1 = store, 0 = load
m0_mode / m1_mode  in  3  001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned
m0_addr / m1_addr  in  WIDTH  byte address
m0_wdata / m1_wdata  in  WIDTH  store data
m0_gnt / m1_gnt  out  1  one-cycle pulse; request has been issued to memory
m0_rvalid / m1_rvalid  out  1  one-cycle pulse; access complete
m0_rdata / m1_rdata  out  WIDTH  load data, valid with rvalid; 0 for stores and errors
m0_err / m1_err  out  1  valid with rvalid; access rejected
mem_A  out  WIDTH  memory address
mem_WD  out  WIDTH  memory write data
mem_WE  out  1  memory write enable
mem_modeBU  out  3  memory access mode
mem_ResultSrc  out  2  01 during an issued load, otherwise 00
mem_RD  in  WIDTH  memory read data (combinational from mem_A)

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; starvation counter 0. Reset during ACCESS deasserts mem_WE immediately; the aborted store must not reach memory.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Steady-state throughput is one access per 3 cycles.
- IDLE: if any req is high, select a winner and capture we/mode/addr/wdata/master id at the clock edge; go to ACCESS. Requests may be withdrawn while in IDLE with no effect.
- Arbitration: master 0 has fixed priority. Exception: if the starvation counter equals STARVE_MAX and m1_req is high, master 1 wins.
- Starvation counter: increments, saturating at STARVE_MAX, on each capture where m1_req is high and master 0 wins. Clears when master 1 is captured or when m1_req is low in IDLE.
- ACCESS (1 cycle): drive mem_A, mem_WD and mem_modeBU from the captured request. mem_WE equals the captured we; the store commits on the edge that ends ACCESS. Drive mem_ResultSrc = 01 for a load. Pulse the winner's gnt. Register mem_RD into a response buffer on the edge that ends ACCESS. The captured access completes even if req drops.
- RESP (1 cycle): pulse the winner's rvalid and drive its rdata from the buffer. Return to IDLE.
- Rejection: an address >= ADDR_LIMIT or a mode outside 001-101 is flagged at capture. Such an access still passes through ACCESS/RESP timing, but mem_WE stays 0 and mem_ResultSrc stays 00. The response is err=1 and rdata=0.
- Outside ACCESS: mem_A, mem_WD, mem_WE, mem_modeBU and mem_ResultSrc are all 0.
- A non-winning master's gnt, rvalid, err and rdata are 0.
- Simultaneous requests: only one master is captured; the loser keeps req high and is arbitrated again in the next IDLE.

Optional Feature:
DMEM_ARB_ALIGN_CHECK_EN
- Defined: a word access with addr[1:0] != 0, or a half access with addr[0] != 0, is rejected at capture, using the same err path and no memory access.
- Undefined: no alignment check; the address is passed to memory unchanged.

Test Plan:
- m0 stores word 32'hDEADBEEF to 32'h100, then loads word from 32'h100 -> gnt in cycle 2, rvalid in cycle 3, rdata 32'hDEADBEEF, err 0, mem_WE high exactly one cycle.
- m0 and m1 both held requesting continuously -> grant order m0 x4, then m1, then m0 repeats (STARVE_MAX = 4); m1 is never starved.
- m1 loads byte from an address holding 8'h80 with mode 011, then with mode 101 -> rdata 32'hFFFFFF80, then 32'h00000080.
- m0 stores to 32'h00020000 -> err 1, rdata 0, mem_WE never asserted, memory contents unchanged.
- rst_n asserted low mid-ACCESS of an m0 store -> mem_WE drops immediately, state IDLE, no rvalid pulse, target byte unchanged.
- With DMEM_ARB_ALIGN_CHECK_EN, a word load at 32'h102 -> err 1. Without the macro, the same load -> err 0.
